// File: rtl/fetch_if.sv
// fetch_if: signal bundle between the fetch stage and its neighbours
// (instruction memory, decode, branch/jump resolution).
//
// ifidValid semantics: ifidValid is the only qualifier on the IF/ID
// register. When it is 1, ifidInstr/ifidPcPlus4 describe a real fetched
// instruction. There is no ready signal: decode applies backpressure with
// stall. While stall=1 the stage holds IF/ID and PC and ignores redirects.
//
// Modports:
//   master - the fetch stage (drives imAddr and the IF/ID outputs)
//   slave  - the environment (drives imData, stall and redirect inputs)
interface fetch_if;
  logic [31:0] imAddr;
  logic [31:0] imData;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchOffset;
  logic        jump;
  logic [25:0] jumpIndex;
  logic        jumpReg;
  logic [31:0] regTarget;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPcPlus4;
  logic        ifidValid;
  logic        misaligned;

  modport master (
    output imAddr, ifidInstr, ifidPcPlus4, ifidValid, misaligned,
    input  imData, stall, branchTaken, branchOffset, jump, jumpIndex,
           jumpReg, regTarget
  );

  modport slave (
    input  imAddr, ifidInstr, ifidPcPlus4, ifidValid, misaligned,
    output imData, stall, branchTaken, branchOffset, jump, jumpIndex,
           jumpReg, regTarget
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, selects the next PC
// (sequential / branch / jump / jump-register), drives the instruction
// memory address and captures the fetched word plus its PC+4 into the
// IF/ID pipeline register.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - fetch_if.master (imAddr/imData, stall, redirect inputs,
//          IF/ID outputs, sticky misaligned flag)
//
// Build option: define BRANCH_DELAY_SLOT_EN to keep the sequentially
// fetched instruction (delay slot) on a redirect edge instead of
// flushing it. Default build flushes it, giving a one-bubble penalty.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPcPlus4;
  logic        ifidValid;
  logic        misaligned;

  // Redirect decision (combinational from decode)
  logic        redirectEn;
  logic        redirect;
  logic [31:0] target;
  logic        jrMisaligned;

  assign pcPlus4 = pc + 32'd4;

  // Redirects describe the instruction in IF/ID, so they only count when
  // that instruction is real and the pipe is advancing.
  assign redirectEn = !bus.stall && ifidValid;
  assign redirect   = redirectEn &&
                      (bus.jumpReg || bus.jump || bus.branchTaken);

  always_comb begin
    target = pcPlus4;
    if (bus.jumpReg) begin
      target = {bus.regTarget[31:2], 2'b00};
    end else if (bus.jump) begin
      target = {ifidPcPlus4[31:28], bus.jumpIndex, 2'b00};
    end else if (bus.branchTaken) begin
      // Offset is in words; wraps modulo 2^32.
      target = ifidPcPlus4 + {bus.branchOffset[29:0], 2'b00};
    end
  end

  assign jrMisaligned = redirectEn && bus.jumpReg &&
                        (bus.regTarget[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      ifidInstr   <= NOP_INSTR;
      ifidPcPlus4 <= 32'h0000_0000;
      ifidValid   <= 1'b0;
      misaligned  <= 1'b0;
    end else if (!bus.stall) begin
      ifidPcPlus4 <= pcPlus4;
      if (redirect) begin
        pc <= target;
`ifdef BRANCH_DELAY_SLOT_EN
        // Delay slot: the sequentially fetched word still executes.
        ifidInstr <= bus.imData;
        ifidValid <= 1'b1;
`else
        // Wrong-path word is squashed into a bubble.
        ifidInstr <= NOP_INSTR;
        ifidValid <= 1'b0;
`endif
      end else begin
        pc        <= pcPlus4;
        ifidInstr <= bus.imData;
        ifidValid <= 1'b1;
      end
      if (jrMisaligned) begin
        misaligned <= 1'b1;
      end
    end
  end

  assign bus.imAddr      = pc;
  assign bus.ifidInstr   = ifidInstr;
  assign bus.ifidPcPlus4 = ifidPcPlus4;
  assign bus.ifidValid   = ifidValid;
  assign bus.misaligned  = misaligned;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  fetch_if bus ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory model: word at address a is 0x1000_0000 | a.
  assign bus.imData = 32'h1000_0000 | bus.imAddr;

  int checks   = 0;
  int failures = 0;

  // Watchdog: the run is a fixed number of edges, this only guards hangs.
  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout, required finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] off;
    logic        jmp;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] rt;
    logic [31:0] ePc;
    logic [31:0] eInstr;
    logic [31:0] eP4;
    logic        eV;
    logic        eMis;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic rst_i, input logic stall_i,
    input logic br_i, input logic [31:0] off_i,
    input logic jmp_i, input logic [25:0] idx_i,
    input logic jr_i, input logic [31:0] rt_i,
    input logic [31:0] pc_i, input logic [31:0] instr_i,
    input logic [31:0] p4_i, input logic v_i, input logic mis_i);
    vec_t v;
    v.rst = rst_i; v.stall = stall_i; v.br = br_i; v.off = off_i;
    v.jmp = jmp_i; v.idx = idx_i; v.jr = jr_i; v.rt = rt_i;
    v.ePc = pc_i; v.eInstr = instr_i; v.eP4 = p4_i; v.eV = v_i;
    v.eMis = mis_i;
    return v;
  endfunction

  // Wrong-path slot contents on a redirect edge.
`ifdef BRANCH_DELAY_SLOT_EN
  function automatic logic [31:0] slotI(input logic [31:0] a);
    return 32'h1000_0000 | a;
  endfunction
  localparam logic SLOT_V = 1'b1;
`else
  function automatic logic [31:0] slotI(input logic [31:0] a);
    return 32'h0000_0000 + (a & 32'h0);
  endfunction
  localparam logic SLOT_V = 1'b0;
`endif

  task automatic fill_vectors();
    //            rst st br off           jmp idx         jr rt            ePc           eInstr                 eP4           eV     eMis
    vecs[0]  = mk(1, 0, 0, 32'h0,         0, 26'h0,       0, 32'h0,        32'h0,        32'h0,                 32'h0,        0,     0);
    vecs[1]  = mk(0, 0, 0, 32'h0,         0, 26'h0,       0, 32'h0,        32'h4,        32'h1000_0000,         32'h4,        1,     0);
    vecs[2]  = mk(0, 0, 0, 32'h0,         0, 26'h0,       0, 32'h0,        32'h8,        32'h1000_0004,         32'h8,        1,     0);
    vecs[3]  = mk(0, 0, 0, 32'h0,         0, 26'h0,       0, 32'h0,        32'hC,        32'h1000_0008,         32'hC,        1,     0);
    vecs[4]  = mk(0, 0, 0, 32'h0,         0, 26'h0,       0, 32'h0,        32'h10,       32'h1000_000C,         32'h10,       1,     0);
    // branch: ifidPcPlus4=0x10, offset -4 words -> target 0
    vecs[5]  = mk(0, 0, 1, 32'hFFFF_FFFC, 0, 26'h0,       0, 32'h0,        32'h0,        slotI(32'h10),         32'h14,       SLOT_V, 0);
    // default: IF/ID invalid, branch ignored. delay-slot: branch retaken to 4. Same result.
    vecs[6]  = mk(0, 0, 1, 32'hFFFF_FFFC, 0, 26'h0,       0, 32'h0,        32'h4,        32'h1000_0000,         32'h4,        1,     0);
    // stall with branch held high: everything holds
    vecs[7]  = mk(0, 1, 1, 32'hFFFF_FFFC, 0, 26'h0,       0, 32'h0,        32'h4,        32'h1000_0000,         32'h4,        1,     0);
    vecs[8]  = mk(0, 1, 1, 32'hFFFF_FFFC, 0, 26'h0,       0, 32'h0,        32'h4,        32'h1000_0000,         32'h4,        1,     0);
    vecs[9]  = mk(0, 1, 1, 32'hFFFF_FFFC, 0, 26'h0,       0, 32'h0,        32'h4,        32'h1000_0000,         32'h4,        1,     0);
    vecs[10] = mk(0, 0, 0, 32'h0,         0, 26'h0,       0, 32'h0,        32'h8,        32'h1000_0004,         32'h8,        1,     0);
    // aligned JR to 0x4000_0004
    vecs[11] = mk(0, 0, 0, 32'h0,         0, 26'h0,       1, 32'h4000_0004, 32'h4000_0004, slotI(32'h8),        32'hC,        SLOT_V, 0);
    vecs[12] = mk(0, 0, 0, 32'h0,         0, 26'h0,       0, 32'h0,        32'h4000_0008, 32'h5000_0004,        32'h4000_0008, 1,    0);
    // jump with ifidPcPlus4=0x4000_0008, index 0x40 -> 0x4000_0100
    vecs[13] = mk(0, 0, 0, 32'h0,         1, 26'h40,      0, 32'h0,        32'h4000_0100, slotI(32'h4000_0008), 32'h4000_000C, SLOT_V, 0);
    vecs[14] = mk(0, 0, 0, 32'h0,         0, 26'h0,       0, 32'h0,        32'h4000_0104, 32'h5000_0100,        32'h4000_0104, 1,    0);
    // all redirects at once: JR wins, misaligned target 0x203 -> 0x200
    vecs[15] = mk(0, 0, 1, 32'h10,        1, 26'h123,     1, 32'h0000_0203, 32'h200,      slotI(32'h4000_0104), 32'h4000_0108, SLOT_V, 1);
    vecs[16] = mk(0, 0, 0, 32'h0,         0, 26'h0,       0, 32'h0,        32'h204,       32'h1000_0200,        32'h204,      1,     1);
    // JR to last word, then sequential wrap to 0
    vecs[17] = mk(0, 0, 0, 32'h0,         0, 26'h0,       1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, slotI(32'h204),      32'h208,      SLOT_V, 1);
    vecs[18] = mk(0, 0, 0, 32'h0,         0, 26'h0,       0, 32'h0,        32'h0,         32'hFFFF_FFFC,        32'h0,        1,     1);
    vecs[19] = mk(0, 0, 0, 32'h0,         0, 26'h0,       0, 32'h0,        32'h4,         32'h1000_0000,        32'h4,        1,     1);
    // reset during a redirect wins, clears sticky flag
    vecs[20] = mk(1, 0, 1, 32'h40,        0, 26'h0,       0, 32'h0,        32'h0,         32'h0,                32'h0,        0,     0);
    vecs[21] = mk(0, 0, 0, 32'h0,         0, 26'h0,       0, 32'h0,        32'h4,         32'h1000_0000,        32'h4,        1,     0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    rst              = v.rst;
    bus.stall        = v.stall;
    bus.branchTaken  = v.br;
    bus.branchOffset = v.off;
    bus.jump         = v.jmp;
    bus.jumpIndex    = v.idx;
    bus.jumpReg      = v.jr;
    bus.regTarget    = v.rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] ePc,
                           input logic [31:0] eInstr, input logic [31:0] eP4,
                           input logic eV, input logic eMis);
    chk({tag, ".imAddr"},      bus.imAddr,             ePc);
    chk({tag, ".ifidInstr"},   bus.ifidInstr,          eInstr);
    chk({tag, ".ifidPcPlus4"}, bus.ifidPcPlus4,        eP4);
    chk({tag, ".ifidValid"},   {31'b0, bus.ifidValid}, {31'b0, eV});
    chk({tag, ".misaligned"},  {31'b0, bus.misaligned}, {31'b0, eMis});
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t idle;
    int k;
    fill_vectors();
    drive(vecs[0]);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      step();
      chk_state($sformatf("vec%0d", i), vecs[i].ePc, vecs[i].eInstr,
                vecs[i].eP4, vecs[i].eV, vecs[i].eMis);
    end

    // Random-length stall with jump and a misaligned JR held high:
    // nothing moves and the sticky flag must not set.
    idle = mk(0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0,
              32'h0, 32'h0, 32'h0, 0, 0);
    k = $urandom_range(2, 5);
    for (int c = 0; c < k; c++) begin
      drive(idle);
      bus.stall     = 1'b1;
      bus.jump      = 1'b1;
      bus.jumpIndex = 26'h100;
      bus.jumpReg   = 1'b1;
      bus.regTarget = 32'h0000_0003;
      step();
      chk_state($sformatf("stall%0d", c), 32'h4, 32'h1000_0000, 32'h4,
                1'b1, 1'b0);
    end
    // Release: fetch resumes at PC + 4.
    drive(idle);
    step();
    chk_state("resume0", 32'h8, 32'h1000_0004, 32'h8, 1'b1, 1'b0);
    step();
    chk_state("resume1", 32'hC, 32'h1000_0008, 32'hC, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
